// File: rtl/line_sensor_proc.sv
// line_sensor_proc
//   Smooths four 12-bit line-sensor readings (two-tap average), binarises
//   each with hysteresis, maps the 4-bit pattern to a signed steering error
//   and tracks FOLLOW / NODE / LOST once per frame, counting node entries.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   frame_valid        one-cycle strobe: adc1..adc4 hold a new frame
//   adc1..adc4         raw readings, sensor 1 (leftmost) .. sensor 4
//   line_bits          thresholded bits, bit i = sensor i+1
//   pos_err            signed steering error -3 .. +3
//   fsm_state          0=FOLLOW, 1=NODE, 2=LOST
//   node_count         node entries since reset (wraps)
//   node_pulse         one-cycle pulse on entry to NODE
//   out_valid          one-cycle pulse, outputs reflect a new frame
// Latency frame_valid -> out_valid is 2 cycles; one frame per cycle accepted.
module line_sensor_proc #(
  parameter logic [11:0] THRESH_HI     = 12'd2200,
  parameter logic [11:0] THRESH_LO     = 12'd1800,
  parameter int unsigned NODE_DEBOUNCE = 3,
  parameter int unsigned LOST_TIMEOUT  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_valid,
  input  logic [11:0]       adc1,
  input  logic [11:0]       adc2,
  input  logic [11:0]       adc3,
  input  logic [11:0]       adc4,
  output logic [3:0]        line_bits,
  output logic signed [2:0] pos_err,
  output logic [1:0]        fsm_state,
  output logic [7:0]        node_count,
  output logic              node_pulse,
  output logic              out_valid
);

  typedef enum logic [1:0] {FOLLOW = 2'd0, NODE = 2'd1, LOST = 2'd2} state_t;

  localparam logic [3:0] ND = 4'(NODE_DEBOUNCE);
  localparam logic [7:0] LT = 8'(LOST_TIMEOUT);

  // ---------------- stage 1: averaging + hysteresis ----------------
  logic [11:0] cur  [4];
  logic [11:0] prev [4];
  logic [12:0] sum  [4];
  logic [11:0] avg  [4];
  logic        first;      // no previous sample yet: average equals current
  logic [3:0]  hyst;
  logic [3:0]  hyst_next;
  logic        s1_valid;

  always_comb begin
    cur[0] = adc1;
    cur[1] = adc2;
    cur[2] = adc3;
    cur[3] = adc4;
  end

  always_comb begin
    hyst_next = hyst;
    for (int unsigned ch = 0; ch < 4; ch++) begin
      sum[ch] = {1'b0, cur[ch]} + {1'b0, (first ? cur[ch] : prev[ch])};
      avg[ch] = sum[ch][12:1];
      if (avg[ch] >= THRESH_HI)
        hyst_next[ch] = 1'b1;
      else if (avg[ch] < THRESH_LO)
        hyst_next[ch] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev     <= '{default: '0};
      first    <= 1'b1;
      hyst     <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= frame_valid;
      if (frame_valid) begin
        prev  <= cur;
        first <= 1'b0;
        hyst  <= hyst_next;
      end
    end
  end

  // ---------------- stage 2: classification + FSM ----------------
  logic [2:0]        n;
  logic              tbl_ok;
  logic signed [2:0] tbl_err;
  logic              line_seen;
  logic [3:0]        node_cnt, nc_next;
  logic [7:0]        empty_cnt, ec_next;
  state_t            state;

  always_comb begin
    n         = 3'($countones(hyst));
    line_seen = (n == 3'd1) || (n == 3'd2);
    tbl_ok    = 1'b1;
    tbl_err   = '0;
    case (hyst)
      4'b0001: tbl_err = -3'sd3;
      4'b0011: tbl_err = -3'sd2;
      4'b0010: tbl_err = -3'sd1;
      4'b0110: tbl_err =  3'sd0;
      4'b0100: tbl_err =  3'sd1;
      4'b1100: tbl_err =  3'sd2;
      4'b1000: tbl_err =  3'sd3;
      default: tbl_ok  = 1'b0;
    endcase
    nc_next = '0;
    if (n >= 3'd3)
      nc_next = (node_cnt >= ND) ? node_cnt : node_cnt + 4'd1;
    ec_next = '0;
    if (n == 3'd0)
      ec_next = (empty_cnt >= LT) ? empty_cnt : empty_cnt + 8'd1;
  end

  // Last direction kept when the line is lost, pushed to full deflection.
  function automatic logic signed [2:0] sat_sign(input logic signed [2:0] e);
    if (e < 0)      return -3'sd3;
    else if (e > 0) return  3'sd3;
    else            return  3'sd0;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FOLLOW;
      line_bits  <= '0;
      pos_err    <= '0;
      node_count <= '0;
      node_pulse <= 1'b0;
      out_valid  <= 1'b0;
      node_cnt   <= '0;
      empty_cnt  <= '0;
    end else begin
      out_valid  <= 1'b0;
      node_pulse <= 1'b0;
      if (s1_valid) begin
        out_valid <= 1'b1;
        line_bits <= hyst;
        node_cnt  <= nc_next;
        empty_cnt <= ec_next;
        case (state)
          FOLLOW: begin
            if (nc_next == ND) begin
              state      <= NODE;
              node_count <= node_count + 8'd1;
              node_pulse <= 1'b1;
              pos_err    <= '0;
            end else if (ec_next == LT) begin
              state   <= LOST;
              pos_err <= sat_sign(pos_err);
            end else if (tbl_ok) begin
              pos_err <= tbl_err;
            end
          end
          NODE: begin
            if (line_seen) begin
              state <= FOLLOW;
              if (tbl_ok) pos_err <= tbl_err;
            end else if (ec_next == LT) begin
              state   <= LOST;
              pos_err <= sat_sign(pos_err);
            end else begin
              pos_err <= '0;
            end
          end
          LOST: begin
            if (line_seen) begin
              state <= FOLLOW;
              if (tbl_ok) pos_err <= tbl_err;
            end
          end
          default: state <= FOLLOW;
        endcase
      end
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_line_sensor_proc.sv
// Testbench for line_sensor_proc: directed table + hand sequences, then
// randomized frames compared against a behavioural model.
module tb_line_sensor_proc;

  localparam int HI = 2200;
  localparam int LO = 1800;
  localparam int ND = 3;
  localparam int LT = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              frame_valid;
  logic [11:0]       adc1, adc2, adc3, adc4;
  logic [3:0]        line_bits;
  logic signed [2:0] pos_err;
  logic [1:0]        fsm_state;
  logic [7:0]        node_count;
  logic              node_pulse;
  logic              out_valid;

  line_sensor_proc #(
    .THRESH_HI(12'(HI)),
    .THRESH_LO(12'(LO)),
    .NODE_DEBOUNCE(ND),
    .LOST_TIMEOUT(LT)
  ) dut (
    .clk(clk), .rst(rst), .frame_valid(frame_valid),
    .adc1(adc1), .adc2(adc2), .adc3(adc3), .adc4(adc4),
    .line_bits(line_bits), .pos_err(pos_err), .fsm_state(fsm_state),
    .node_count(node_count), .node_pulse(node_pulse), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {int bits; int err; int st; int cnt; int pulse;} exp_t;
  typedef struct {int mask; int bits; int err; int st;} vec_t;

  exp_t expq[$];
  int n_vec = 0;
  int n_bad = 0;
  int ov_seen = 0;
  int pulse_seen = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_prev[4];
  bit m_first;
  bit m_on[4];
  int m_ncnt, m_ecnt, m_mode, m_err, m_nodes;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin m_prev[i] = 0; m_on[i] = 0; end
    m_first = 1; m_ncnt = 0; m_ecnt = 0; m_mode = 0; m_err = 0; m_nodes = 0;
  endtask

  task automatic model_frame(input int a[4], output exp_t e);
    int n, sumpos, lo, hi, bits, p, avg, terr;
    bit ok, seen;
    n = 0; sumpos = 0; lo = -1; hi = -1; bits = 0;
    for (int ch = 0; ch < 4; ch++) begin
      p   = m_first ? a[ch] : m_prev[ch];
      avg = (p + a[ch]) / 2;
      if (avg >= HI) m_on[ch] = 1;
      else if (avg < LO) m_on[ch] = 0;
      m_prev[ch] = a[ch];
      if (m_on[ch]) begin
        n++; sumpos += ch; bits += (1 << ch);
        if (lo < 0) lo = ch;
        hi = ch;
      end
    end
    m_first = 0;
    // single sensor or adjacent pair: error is the centroid, scaled to -3..+3
    ok   = (n == 1) || (n == 2 && hi - lo == 1);
    terr = ok ? (2 * sumpos) / n - 3 : 0;
    seen = (n == 1) || (n == 2);
    m_ncnt = (n >= 3) ? ((m_ncnt + 1 > ND) ? ND : m_ncnt + 1) : 0;
    m_ecnt = (n == 0) ? ((m_ecnt + 1 > LT) ? LT : m_ecnt + 1) : 0;
    e.pulse = 0;
    if (m_mode == 0) begin
      if (m_ncnt == ND) begin
        m_mode = 1; m_nodes = (m_nodes + 1) % 256; e.pulse = 1; m_err = 0;
      end else if (m_ecnt == LT) begin
        m_mode = 2; m_err = (m_err > 0) ? 3 : (m_err < 0) ? -3 : 0;
      end else if (ok) m_err = terr;
    end else if (m_mode == 1) begin
      if (seen) begin
        m_mode = 0; if (ok) m_err = terr;
      end else if (m_ecnt == LT) begin
        m_mode = 2; m_err = 0;
      end else m_err = 0;
    end else begin
      if (seen) begin
        m_mode = 0; if (ok) m_err = terr;
      end
    end
    e.bits = bits; e.err = m_err; e.st = m_mode; e.cnt = m_nodes;
  endtask

  // ---------------- drivers ----------------
  task automatic drive(input int a[4]);
    exp_t e;
    @(posedge clk); #1;
    adc1 = 12'(a[0]); adc2 = 12'(a[1]); adc3 = 12'(a[2]); adc4 = 12'(a[3]);
    frame_valid = 1'b1;
    model_frame(a, e);
    expq.push_back(e);
  endtask

  task automatic drive_mask(input int m);
    int a[4];
    for (int i = 0; i < 4; i++) a[i] = ((m >> i) & 1) ? 3000 : 500;
    drive(a);
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge clk); #1;
      frame_valid = 1'b0;
      adc1 = 12'($urandom); adc2 = 12'($urandom);
      adc3 = 12'($urandom); adc4 = 12'($urandom);
    end
  endtask

  // Wait until the frame just driven has reached the outputs.
  task automatic settle();
    idle(1);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_bits"},  int'(line_bits), 0);
    chk({tag, "_err"},   int'(pos_err), 0);
    chk({tag, "_state"}, int'(fsm_state), 0);
    chk({tag, "_cnt"},   int'(node_count), 0);
    chk({tag, "_pulse"}, int'(node_pulse), 0);
    chk({tag, "_valid"}, int'(out_valid), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; frame_valid = 1'b0;
    expq.delete(); model_reset();
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // ---------------- output monitor ----------------
  bit   h1 = 0, h2 = 0;
  exp_t last = '{0, 0, 0, 0, 0};
  exp_t got;

  always @(negedge clk) begin
    if (rst) begin
      h1 = 0; h2 = 0;
      last = '{0, 0, 0, 0, 0};
    end else begin
      chk("out_valid_timing", int'(out_valid), int'(h2));
      if (out_valid) begin
        ov_seen++;
        if (node_pulse) pulse_seen++;
        if (expq.size() == 0) begin
          chk("unexpected_out_valid", 1, 0);
        end else begin
          got = expq.pop_front();
          chk("line_bits", int'(line_bits), got.bits);
          chk("pos_err", int'(pos_err), got.err);
          chk("fsm_state", int'(fsm_state), got.st);
          chk("node_count", int'(node_count), got.cnt);
          chk("node_pulse", int'(node_pulse), got.pulse);
          last = got;
        end
      end else begin
        chk("hold_bits", int'(line_bits), last.bits);
        chk("hold_err", int'(pos_err), last.err);
        chk("pulse_idle", int'(node_pulse), 0);
      end
      h2 = h1;
      h1 = frame_valid;
    end
  end

  // ---------------- test sequence ----------------
  vec_t tbl[22];
  int   hv[6];
  int   hx[6];
  int   a[4];
  int   snap_ov, snap_pulse;

  function automatic vec_t mk(input int m, input int b, input int e, input int s);
    vec_t v;
    v.mask = m; v.bits = b; v.err = e; v.st = s;
    return v;
  endfunction

  initial begin
    // sweep through every table pattern, then lose the line and recover
    tbl[0]  = mk(4'b0001, 4'b0001, -3, 0);
    tbl[1]  = mk(4'b0011, 4'b0001, -3, 0);
    tbl[2]  = mk(4'b0011, 4'b0011, -2, 0);
    tbl[3]  = mk(4'b0010, 4'b0010, -1, 0);
    tbl[4]  = mk(4'b0110, 4'b0010, -1, 0);
    tbl[5]  = mk(4'b0110, 4'b0110,  0, 0);
    tbl[6]  = mk(4'b0100, 4'b0100,  1, 0);
    tbl[7]  = mk(4'b1100, 4'b0100,  1, 0);
    tbl[8]  = mk(4'b1100, 4'b1100,  2, 0);
    tbl[9]  = mk(4'b1000, 4'b1000,  3, 0);
    tbl[10] = mk(4'b1100, 4'b1000,  3, 0);
    tbl[11] = mk(4'b1100, 4'b1100,  2, 0);
    for (int i = 12; i < 19; i++) tbl[i] = mk(4'b0000, 4'b0000, 2, 0);
    tbl[19] = mk(4'b0000, 4'b0000,  3, 2);
    tbl[20] = mk(4'b0010, 4'b0000,  3, 2);
    tbl[21] = mk(4'b0010, 4'b0010, -1, 0);

    rst = 1'b1; frame_valid = 1'b0;
    adc1 = '0; adc2 = '0; adc3 = '0; adc4 = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk_zero("por");
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 22; i++) begin
      drive_mask(tbl[i].mask);
      settle();
      chk($sformatf("tbl%0d_valid", i), int'(out_valid), 1);
      chk($sformatf("tbl%0d_bits", i), int'(line_bits), tbl[i].bits);
      chk($sformatf("tbl%0d_err", i), int'(pos_err), tbl[i].err);
      chk($sformatf("tbl%0d_state", i), int'(fsm_state), tbl[i].st);
    end

    // reset while a frame is inside the pipeline
    drive_mask(4'b1100);
    @(posedge clk); #2;
    rst = 1'b1; frame_valid = 1'b0;
    expq.delete(); model_reset();
    @(negedge clk);
    chk_zero("midrst_a");
    @(negedge clk);
    chk_zero("midrst_b");
    @(posedge clk); #1;
    rst = 1'b0;
    idle(3);

    // hysteresis on sensor 1
    hv = '{3000, 2000, 2000, 2000, 1500, 1500};
    hx = '{1, 1, 1, 1, 0, 0};
    for (int i = 0; i < 6; i++) begin
      a = '{hv[i], 500, 500, 500};
      drive(a);
      settle();
      chk($sformatf("hyst%0d_bit0", i), int'(line_bits[0]), hx[i]);
    end

    // node debounce, exit, and node_count wrap
    do_reset();
    snap_pulse = pulse_seen;
    for (int i = 0; i < 3; i++) begin
      drive_mask(4'b1111);
      settle();
      chk($sformatf("node%0d_state", i), int'(fsm_state), (i == 2) ? 1 : 0);
      chk($sformatf("node%0d_pulse", i), int'(node_pulse), (i == 2) ? 1 : 0);
    end
    chk("node_count_1", int'(node_count), 1);
    drive_mask(4'b0110);
    settle();
    chk("node_exit_state", int'(fsm_state), 0);
    chk("node_exit_err", int'(pos_err), 0);
    for (int k = 0; k < 255; k++) begin
      repeat (4) drive_mask(4'b1111);
      drive_mask(4'b0110);
    end
    idle(3);
    chk("node_count_wrap", int'(node_count), 0);
    chk("node_pulses", pulse_seen - snap_pulse, 256);

    // back-to-back frames
    snap_ov = ov_seen;
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < 4; c++) a[c] = $urandom_range(0, 4095);
      drive(a);
    end
    idle(3);
    chk("burst_out_valid", ov_seen - snap_ov, 10);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        repeat ($urandom_range(6, 10)) drive_mask(0);
      end else if ($urandom_range(0, 1) == 0) begin
        drive_mask(int'($urandom_range(0, 15)));
      end else begin
        for (int c = 0; c < 4; c++) begin
          case ($urandom_range(0, 6))
            0: a[c] = 500;
            1: a[c] = 1500;
            2: a[c] = 1799;
            3: a[c] = 2199;
            4: a[c] = 2200;
            5: a[c] = 3000;
            default: a[c] = $urandom_range(0, 4095);
          endcase
        end
        drive(a);
      end
      idle($urandom_range(0, 2));
    end
    idle(4);
    chk("queue_drained", expq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
